sram_ctrl_model: RTL and testbench
==================================

# sram_ctrl_model

Parametrised, cycle-accurate synchronous SRAM model for the pipeline's memory stage. It replaces the fixed 64-bit, delay-annotated SRAM model with a clocked request/ready handshake. It adds:
- configurable data width, depth and wait states;
- byte-enable writes;
- an explicit completion pulse that the memory-stage controller uses to freeze the pipeline.

Storage is behavioural (register array); all timing is expressed in CLK cycles, with no `#` delays.

## Interface

Parameters:
- DATA_W, 64 — data bus width in bits; multiple of 8, ≥ 8.
- ADDR_W, 16 — byte-address width of SRAM_ADDR.
- DEPTH, 512 — number of DATA_W-bit words; power of two.
- WAIT_CYCLES, 3 — cycles from request acceptance to completion; ≥ 1.

Ports:
- CLK input 1 — clock; all state changes on rising edge.
- RST_N input 1 — reset, asynchronous, active-low.
- SRAM_EN input 1 — request strobe.
- SRAM_WE_N input 1 — 0 = write, 1 = read; sampled with SRAM_EN.
- SRAM_ADDR input ADDR_W — byte address of request.
- SRAM_BE_N input DATA_W/8 — active-low byte enables; write only.
- SRAM_WDATA input DATA_W — write data.
- SRAM_RDATA output DATA_W — read data; valid while SRAM_READY=1 after a read.
- SRAM_READY output 1 — one-cycle completion pulse (read or write).
- SRAM_BUSY output 1 — high while a request is in flight (state WAIT).

## Operation

- Word index = SRAM_ADDR >> log2(DATA_W/8), taken modulo DEPTH. Upper address bits wrap silently; low byte-offset bits are ignored.
- States: IDLE, WAIT.
- IDLE, SRAM_EN=1 at edge:
  - latch index, WE_N, BE_N and WDATA;
  - load counter with WAIT_CYCLES;
  - go to WAIT.
- IDLE, SRAM_EN=0: stay; nothing latched.
- WAIT, counter > 1: decrement.
- WAIT, counter == 1 at edge, perform the latched operation:
  - write: memory[idx] byte i ← WDATA byte i for every i with BE_N[i]=0; other bytes unchanged;
  - read: SRAM_RDATA ← memory[idx];
  - then SRAM_READY ← 1 and go to IDLE.
- SRAM_EN, address and data are ignored while in WAIT. The in-flight request is unaffected, and the caller must re-present a dropped request.
- Write completion leaves SRAM_RDATA at its previous value.
- All-ones BE_N on a write: memory unchanged; SRAM_READY still pulses.
- SRAM_BUSY = (state == WAIT).

Reset:
- Asserting RST_N=0 at any time immediately forces: state IDLE, counter 0, SRAM_READY 0, SRAM_BUSY 0, SRAM_RDATA 0.
- An in-flight write is aborted and memory is not modified.
- Memory contents are not reset. An unwritten location reads X.

## Timing

- Request accepted at edge k (IDLE, SRAM_EN=1).
- SRAM_BUSY high from after edge k until after edge k+WAIT_CYCLES.
- Completion at edge k+WAIT_CYCLES:
  - SRAM_READY high for exactly the following cycle;
  - write data visible in memory;
  - read data on SRAM_RDATA.
- Next request is accepted at the earliest at edge k+WAIT_CYCLES+1, i.e. in the cycle SRAM_READY is high. Peak throughput: one access per WAIT_CYCLES+1 cycles.
- Read-after-write to the same word, issued back-to-back, returns the new data.
- SRAM_READY stays high for exactly one cycle even if no new request follows. SRAM_RDATA holds until the next read completes or reset.
- WAIT_CYCLES=1: accept at k, complete at k+1, period 2 cycles.

## Test plan

All scenarios use the defaults (DATA_W=64, DEPTH=512, WAIT_CYCLES=3) unless stated.

1. **Reset values.** RST_N=0 mid-cycle → SRAM_READY=0, SRAM_BUSY=0 and SRAM_RDATA=0 immediately, without a clock edge.
2. **Write then read.**
   - Write 0x0123_4567_89AB_CDEF to address 0x0010 (word 2) with BE_N=0x00, accepted at edge k → READY pulses in cycle k+3 to k+4.
   - Read of the same address accepted at edge k+4 → READY and RDATA=0x0123_4567_89AB_CDEF after edge k+7.
3. **Byte enables.**
   - Write 0xFFFF_FFFF_FFFF_FFFF to word 5 with BE_N=0x00.
   - Write 0x1122_3344_5566_7788 to word 5 with BE_N=0xF0.
   - Read word 5 → 0xFFFF_FFFF_5566_7788.
4. **Address wrap.**
   - Write 0xA5 (zero-extended) to byte address 512·8 = 0x1000, which maps to word 0.
   - Read byte address 0x0000 → 0x0000_0000_0000_00A5.
   - Read address 0x0007 → same word, same data.
5. **Request during WAIT.**
   - Read accepted at edge k, then SRAM_EN held high with different address and data at edges k+1..k+2 → exactly one READY pulse at k+3, for the original address.
   - The still-high SRAM_EN is accepted as a new request at edge k+4.
6. **Reset mid-write.**
   - Word 7 preloaded with 0x0.
   - Write 0xDEAD_BEEF to word 7 accepted at edge k; RST_N pulsed low between edges k+1 and k+2 → no READY pulse, BUSY=0.
   - A subsequent read of word 7 returns 0x0.

Source files
------------

// File: rtl/sram_ctrl_model_if.sv
// Request/ready bus between the memory-stage controller (master) and the SRAM model (slave).
interface sram_ctrl_model_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
);
  logic                  SRAM_EN;
  logic                  SRAM_WE_N;
  logic [ADDR_W-1:0]     SRAM_ADDR;
  logic [DATA_W/8-1:0]   SRAM_BE_N;
  logic [DATA_W-1:0]     SRAM_WDATA;
  logic [DATA_W-1:0]     SRAM_RDATA;
  logic                  SRAM_READY;
  logic                  SRAM_BUSY;

  modport master (
    output SRAM_EN, SRAM_WE_N, SRAM_ADDR, SRAM_BE_N, SRAM_WDATA,
    input  SRAM_RDATA, SRAM_READY, SRAM_BUSY
  );

  modport slave (
    input  SRAM_EN, SRAM_WE_N, SRAM_ADDR, SRAM_BE_N, SRAM_WDATA,
    output SRAM_RDATA, SRAM_READY, SRAM_BUSY
  );
endinterface

// File: rtl/sram_ctrl_model.sv
// Cycle-accurate synchronous SRAM model: one request in flight, WAIT_CYCLES latency,
// byte-enable writes and a one-cycle SRAM_READY completion pulse.
module sram_ctrl_model #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  sram_ctrl_model_if.slave sram
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               we_n_q;
  logic [BYTES-1:0]   be_n_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               ready_q;

  logic               accept;
  logic               complete;
  logic               busy;
  logic [IDX_W-1:0]   req_idx;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Dropping the byte offset and truncating to IDX_W gives the silent wrap modulo DEPTH.
  assign req_idx = IDX_W'(sram.SRAM_ADDR >> OFF_W);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this combinational block free of latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sram.SRAM_EN)            state_d = WAIT;
      WAIT:    if (cnt_q == CNT_W'(1))      state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    complete = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: accept = sram.SRAM_EN;
      WAIT: begin
        busy     = 1'b1;
        complete = (cnt_q == CNT_W'(1));
      end
      default: ;
    endcase
  end

  // Request latches, wait counter and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= complete;
      if (accept) begin
        cnt_q   <= CNT_W'(WAIT_CYCLES);
        idx_q   <= req_idx;
        we_n_q  <= sram.SRAM_WE_N;
        be_n_q  <= sram.SRAM_BE_N;
        wdata_q <= sram.SRAM_WDATA;
      end else if (complete) begin
        cnt_q <= '0;
        if (we_n_q) rdata_q <= mem[idx_q];
      end else if (busy) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive RST_N and unwritten words stay X.
  // Reset forces IDLE, so complete is low and an aborted write never reaches the array.
  always_ff @(posedge CLK) begin
    if (complete && !we_n_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!be_n_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  assign sram.SRAM_RDATA = rdata_q;
  assign sram.SRAM_READY = ready_q;
  assign sram.SRAM_BUSY  = busy;

endmodule

// File: tb/tb_sram_ctrl_model.sv
// Scoreboard bench for sram_ctrl_model: driver pushes expected completions, monitor checks READY pulses.
module tb_sram_ctrl_model;

  localparam int W     = 3;
  localparam int DEPTH = 512;

  typedef struct {
    int          cyc;
    logic [63:0] rdata;
    string       tag;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  sram_ctrl_model_if #(.DATA_W(64), .ADDR_W(16)) bus ();

  sram_ctrl_model #(
    .DATA_W(64), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(W)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .sram (bus)
  );

  // Reference model: word array plus the value RDATA is supposed to hold.
  logic [63:0] mdl [int];
  logic [63:0] last_rd = 64'h0;
  exp_t        exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] model_apply(input logic we_n, input int addr,
                                              input logic [7:0] be_n, input logic [63:0] wd);
    int          i;
    logic [63:0] w;
    i = (addr / 8) % DEPTH;
    w = mdl.exists(i) ? mdl[i] : 64'h0;
    if (!we_n) begin
      for (int b = 0; b < 8; b++) if (!be_n[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      mdl[i] = w;
    end else begin
      last_rd = w;
    end
    return last_rd;
  endfunction

  task automatic drive(input logic we_n, input int addr, input logic [7:0] be_n, input logic [63:0] wd);
    bus.SRAM_EN    = 1'b1;
    bus.SRAM_WE_N  = we_n;
    bus.SRAM_ADDR  = 16'(addr);
    bus.SRAM_BE_N  = be_n;
    bus.SRAM_WDATA = wd;
  endtask

  // Called with a request on the bus while the DUT is idle; it is accepted on the next edge.
  task automatic accept(input logic [63:0] rd, input string tag);
    exp_t e;
    @(posedge CLK);
    @(negedge CLK);
    e.cyc   = cyc + W;
    e.rdata = rd;
    e.tag   = tag;
    exp_q.push_back(e);
    check({"busy_", tag}, {63'h0, bus.SRAM_BUSY}, 64'h1);
  endtask

  task automatic wait_ready(input string tag);
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (bus.SRAM_READY === 1'b1) return;
    end
    check({"timeout_", tag}, 64'h0, 64'h1);
  endtask

  task automatic issue(input logic we_n, input int addr, input logic [7:0] be_n,
                       input logic [63:0] wd, input string tag);
    logic [63:0] r;
    drive(we_n, addr, be_n, wd);
    r = model_apply(we_n, addr, be_n, wd);
    accept(r, tag);
    bus.SRAM_EN = 1'b0;
    wait_ready(tag);
  endtask

  // Monitor: every READY pulse must match the oldest outstanding request.
  exp_t mon_e;
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && bus.SRAM_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'h1, 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check({"cycle_", mon_e.tag}, 64'(cyc), 64'(mon_e.cyc));
        check({"rdata_", mon_e.tag}, bus.SRAM_RDATA, mon_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r;
    int          addr;

    bus.SRAM_EN = 1'b0; bus.SRAM_WE_N = 1'b1; bus.SRAM_ADDR = '0;
    bus.SRAM_BE_N = '1; bus.SRAM_WDATA = '0;
    RST_N = 1'b0;
    #1;
    check("rst_ready", {63'h0, bus.SRAM_READY}, 64'h0);
    check("rst_busy",  {63'h0, bus.SRAM_BUSY},  64'h0);
    check("rst_rdata", bus.SRAM_RDATA, 64'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int w = 0; w < 16; w++) issue(1'b0, w * 8, 8'h00, {$urandom, $urandom}, "preload");

    // Write then read back-to-back, word 2.
    issue(1'b0, 'h0010, 8'h00, 64'h0123_4567_89AB_CDEF, "s2_write");
    issue(1'b1, 'h0010, 8'h00, 64'h0, "s2_read");

    // Byte enables on word 5.
    issue(1'b0, 5 * 8, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, "s3_w_all");
    issue(1'b0, 5 * 8, 8'hF0, 64'h1122_3344_5566_7788, "s3_w_low");
    issue(1'b1, 5 * 8, 8'h00, 64'h0, "s3_read");
    issue(1'b0, 5 * 8, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, "s3_w_none");
    issue(1'b1, 5 * 8, 8'h00, 64'h0, "s3_read2");

    // Address wrap and ignored byte offset.
    issue(1'b0, 'h1000, 8'h00, 64'h0000_0000_0000_00A5, "s4_write");
    issue(1'b1, 'h0000, 8'h00, 64'h0, "s4_read0");
    issue(1'b1, 'h0007, 8'h00, 64'h0, "s4_read7");

    // Request during WAIT: held EN is ignored until READY, then accepted.
    drive(1'b1, 'h0010, 8'h00, 64'h0);
    r = model_apply(1'b1, 'h0010, 8'h00, 64'h0);
    accept(r, "s5_read");
    drive(1'b0, 'h0030, 8'h00, 64'hCAFE_F00D_1234_5678);
    wait_ready("s5_read");
    r = model_apply(1'b0, 'h0030, 8'h00, 64'hCAFE_F00D_1234_5678);
    accept(r, "s5_held");
    bus.SRAM_EN = 1'b0;
    wait_ready("s5_held");
    issue(1'b1, 'h0030, 8'h00, 64'h0, "s5_readback");

    // Randomised traffic over 16 words with random offsets and wrap bits.
    for (int n = 0; n < 40; n++) begin
      addr = int'($urandom_range(0, 15)) * 4096 + int'($urandom_range(0, 15)) * 8
           + int'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), addr, 8'($urandom), {$urandom, $urandom}, "rand");
    end

    // Reset asserted mid-cycle while READY is high.
    issue(1'b1, 'h0010, 8'h00, 64'h0, "pre_reset_read");
    #1 RST_N = 1'b0;
    #1;
    check("midrst_ready", {63'h0, bus.SRAM_READY}, 64'h0);
    check("midrst_busy",  {63'h0, bus.SRAM_BUSY},  64'h0);
    check("midrst_rdata", bus.SRAM_RDATA, 64'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    last_rd = 64'h0;

    // Reset aborts an in-flight write to word 7.
    issue(1'b0, 7 * 8, 8'h00, 64'h0, "s6_preload");
    drive(1'b0, 7 * 8, 8'h00, 64'h0000_0000_DEAD_BEEF);
    @(posedge CLK);
    @(negedge CLK);
    bus.SRAM_EN = 1'b0;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("s6_ready", {63'h0, bus.SRAM_READY}, 64'h0);
    check("s6_busy",  {63'h0, bus.SRAM_BUSY},  64'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK);
      check("s6_no_ready", {63'h0, bus.SRAM_READY}, 64'h0);
    end
    issue(1'b1, 7 * 8, 8'h00, 64'h0, "s6_read");

    repeat (4) @(negedge CLK);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
